// File: rtl/rx_fifo_if.sv
// Handshake bundle between the UART receiver, the rx FIFO controller and the host.
// The master modport is the receiver/host side; the slave modport is the FIFO controller.
interface rx_fifo_if #(
  parameter int ADDR_BITS = 3
);
  logic [7:0]         rx_data;
  logic               data_ready;
  logic               overrun_error;
  logic               framing_error;
  logic               data_read;
  logic               fifo_pop;
  logic [7:0]         fifo_data;
  logic               fifo_ferr;
  logic               fifo_oerr;
  logic               fifo_empty;
  logic               fifo_full;
  logic [ADDR_BITS:0] fifo_count;
  logic               underflow;
  logic               clear_err;

  modport master (
    output rx_data, data_ready, overrun_error, framing_error,
    output fifo_pop, clear_err,
    input  data_read, fifo_data, fifo_ferr, fifo_oerr,
    input  fifo_empty, fifo_full, fifo_count, underflow
  );

  modport slave (
    input  rx_data, data_ready, overrun_error, framing_error,
    input  fifo_pop, clear_err,
    output data_read, fifo_data, fifo_ferr, fifo_oerr,
    output fifo_empty, fifo_full, fifo_count, underflow
  );
endinterface

// File: rtl/rx_fifo_ctrl.sv
// Captures received bytes plus framing/overrun flags into a circular FIFO and
// serves them to the host through a show-ahead pop port.
module rx_fifo_ctrl #(
  parameter int ADDR_BITS = 3
) (
  input  logic        clk,
  input  logic        n_rst,
  rx_fifo_if.slave    bus
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic                 push;
  logic                 pop_ok;
  logic [ADDR_BITS-1:0] wptr, rptr;
  logic [ADDR_BITS:0]   count, count_nxt;
  logic                 empty_q, full_q;
  logic                 underflow_q;
  logic [9:0]           mem [DEPTH];
  logic [9:0]           head;

  // Capture FSM: one byte per IDLE->ACK->GAP round, so captures are >= 3 cycles apart.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.data_ready && !full_q) begin
          push      = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign pop_ok = bus.fifo_pop && !empty_q;

  always_comb begin
    count_nxt = count;
    unique case ({push, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= IDLE;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == FULL_CNT);
      if (push)   wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
      // An empty pop sets the flag even when clear_err is asserted alongside it.
      if (bus.fifo_pop && empty_q)
        underflow_q <= 1'b1;
      else if (bus.clear_err)
        underflow_q <= 1'b0;
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {bus.framing_error, bus.overrun_error, bus.rx_data};
  end

  assign head = mem[rptr];

  assign bus.data_read  = (state == ACK);
  assign bus.fifo_data  = empty_q ? 8'h00 : head[7:0];
  assign bus.fifo_oerr  = empty_q ? 1'b0  : head[8];
  assign bus.fifo_ferr  = empty_q ? 1'b0  : head[9];
  assign bus.fifo_empty = empty_q;
  assign bus.fifo_full  = full_q;
  assign bus.fifo_count = count;
  assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Directed bench for rx_fifo_ctrl: capture handshake, full stall, wrap ordering,
// error flags, underflow stickiness and reset during acknowledge.
module tb_rx_fifo_ctrl;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;

  rx_fifo_if #(.ADDR_BITS(3)) bus ();

  rx_fifo_ctrl #(.ADDR_BITS(3)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a byte and hold data_ready until the acknowledge cycle, bounded.
  task automatic send_byte(input logic [7:0] d, input logic fe, input logic oe);
    bit got;
    got = 1'b0;
    bus.rx_data       = d;
    bus.framing_error = fe;
    bus.overrun_error = oe;
    bus.data_ready    = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (bus.data_read === 1'b1) got = 1'b1;
    end
    check("send_ack_seen", 32'(got), 32'd1);
    bus.data_ready    = 1'b0;
    bus.framing_error = 1'b0;
    bus.overrun_error = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] d);
    check(tag, 32'(bus.fifo_data), 32'(d));
    bus.fifo_pop = 1'b1;
    tick();
    bus.fifo_pop = 1'b0;
  endtask

  initial begin
    logic [7:0] q[$];
    bit         saw_ack;

    checks   = 0;
    failures = 0;
    n_rst             = 1'b0;
    bus.rx_data       = 8'h00;
    bus.data_ready    = 1'b0;
    bus.overrun_error = 1'b0;
    bus.framing_error = 1'b0;
    bus.fifo_pop      = 1'b0;
    bus.clear_err     = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_data_read", 32'(bus.data_read), 32'd0);
    check("rst_underflow", 32'(bus.underflow), 32'd0);
    check("rst_empty", 32'(bus.fifo_empty), 32'd1);
    check("rst_full", 32'(bus.fifo_full), 32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_fifo_data", 32'(bus.fifo_data), 32'd0);
    check("rst_ferr_oerr", 32'({bus.fifo_ferr, bus.fifo_oerr}), 32'd0);
    n_rst = 1'b1;
    tick();

    // First capture: ack lands in the cycle after the capture edge
    bus.rx_data    = 8'hA5;
    bus.data_ready = 1'b1;
    #1;
    check("t1_pre_ack", 32'(bus.data_read), 32'd0);
    tick();
    check("t1_ack", 32'(bus.data_read), 32'd1);
    check("t1_count", 32'(bus.fifo_count), 32'd1);
    check("t1_data", 32'(bus.fifo_data), 32'hA5);
    check("t1_empty", 32'(bus.fifo_empty), 32'd0);
    bus.data_ready = 1'b0;
    tick();
    check("t1_gap_no_ack", 32'(bus.data_read), 32'd0);
    tick();
    pop_expect("t1_pop", 8'hA5);
    check("t1_empty_after_pop", 32'(bus.fifo_empty), 32'd1);

    // Fill to full, ninth byte stalls until a pop frees a slot
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0, 1'b0);
    tick();
    tick();
    check("t2_full", 32'(bus.fifo_full), 32'd1);
    check("t2_count8", 32'(bus.fifo_count), 32'd8);
    check("t2_head", 32'(bus.fifo_data), 32'h01);
    bus.rx_data    = 8'h09;
    bus.data_ready = 1'b1;
    saw_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.data_read === 1'b1) saw_ack = 1'b1;
    end
    check("t2_no_ack_full", 32'(saw_ack), 32'd0);
    check("t2_count_held", 32'(bus.fifo_count), 32'd8);
    bus.fifo_pop = 1'b1;
    tick();
    bus.fifo_pop = 1'b0;
    check("t2_pop_first_no_push", 32'(bus.fifo_count), 32'd7);
    check("t2_no_ack_same_edge", 32'(bus.data_read), 32'd0);
    saw_ack = 1'b0;
    for (int i = 0; i < 3 && !saw_ack; i++) begin
      tick();
      if (bus.data_read === 1'b1) saw_ack = 1'b1;
    end
    check("t2_ack_after_pop", 32'(saw_ack), 32'd1);
    check("t2_count_back8", 32'(bus.fifo_count), 32'd8);
    bus.data_ready = 1'b0;
    tick();
    tick();
    for (int i = 2; i <= 9; i++) pop_expect("t2_drain", 8'(i));
    check("t2_empty", 32'(bus.fifo_empty), 32'd1);

    // Interleaved push/pop across pointer wrap
    q = {};
    for (int i = 0; i < 10; i++) begin
      send_byte(8'h40 + 8'(i), 1'b0, 1'b0);
      q.push_back(8'h40 + 8'(i));
      tick();
      tick();
      check("t3_count", 32'(bus.fifo_count), 32'(q.size()));
      check("t3_count_le8", 32'(bus.fifo_count <= 4'd8), 32'd1);
      if (q.size() >= 3) pop_expect("t3_order", q.pop_front());
    end
    while (q.size() > 0) pop_expect("t3_drain", q.pop_front());
    check("t3_empty", 32'(bus.fifo_empty), 32'd1);

    // Error flags travel with their bytes
    send_byte(8'h3C, 1'b1, 1'b0);
    send_byte(8'h3D, 1'b0, 1'b1);
    tick();
    tick();
    check("t4_ferr_oerr_a", 32'({bus.fifo_ferr, bus.fifo_oerr}), 32'b10);
    pop_expect("t4_data_a", 8'h3C);
    check("t4_ferr_oerr_b", 32'({bus.fifo_ferr, bus.fifo_oerr}), 32'b01);
    pop_expect("t4_data_b", 8'h3D);

    // Underflow is sticky; set wins over a simultaneous clear
    bus.fifo_pop = 1'b1;
    tick();
    bus.fifo_pop = 1'b0;
    check("t5_underflow_set", 32'(bus.underflow), 32'd1);
    check("t5_count_zero", 32'(bus.fifo_count), 32'd0);
    tick();
    tick();
    check("t5_underflow_sticky", 32'(bus.underflow), 32'd1);
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    check("t5_underflow_clear", 32'(bus.underflow), 32'd0);
    bus.clear_err = 1'b1;
    bus.fifo_pop  = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    bus.fifo_pop  = 1'b0;
    check("t5_set_wins", 32'(bus.underflow), 32'd1);
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;

    // Reset during ACK discards the acknowledge; byte is re-captured afterwards
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    tick();
    tick();
    bus.rx_data    = 8'h77;
    bus.data_ready = 1'b1;
    saw_ack = 1'b0;
    for (int i = 0; i < 5 && !saw_ack; i++) begin
      tick();
      if (bus.data_read === 1'b1) saw_ack = 1'b1;
    end
    check("t6_in_ack", 32'(saw_ack), 32'd1);
    check("t6_count3", 32'(bus.fifo_count), 32'd3);
    n_rst = 1'b0;
    tick();
    check("t6_rst_no_ack", 32'(bus.data_read), 32'd0);
    check("t6_rst_count", 32'(bus.fifo_count), 32'd0);
    check("t6_rst_empty", 32'(bus.fifo_empty), 32'd1);
    n_rst = 1'b1;
    tick();
    check("t6_recapture_ack", 32'(bus.data_read), 32'd1);
    check("t6_recapture_count", 32'(bus.fifo_count), 32'd1);
    check("t6_recapture_data", 32'(bus.fifo_data), 32'h77);
    bus.data_ready = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_fifo_ctrl.md
Name: rx_fifo_ctrl

Overview:
Downstream consumer of the UART receive block. It takes each completed byte and its framing/overrun status, acknowledges it with a one-cycle data_read pulse, and stores it in a circular FIFO. The host drains the FIFO through a show-ahead pop interface. It decouples host read latency from the serial byte rate, which limits overruns in the receiver.

Parameters:
ADDR_BITS, 3, FIFO address width; depth = 2**ADDR_BITS entries (8).

Ports:
clk  input  1  system clock; all logic is rising-edge.
n_rst  input  1  reset, synchronous, active-low.
rx_data  input  8  received byte from the UART receiver.
data_ready  input  1  receiver holds an unread byte.
overrun_error  input  1  receiver overrun flag, captured with the byte.
framing_error  input  1  receiver framing flag, captured with the byte.
data_read  output  1  one-cycle acknowledge to the receiver.
fifo_pop  input  1  host pop request.
fifo_data  output  8  head-entry byte, show-ahead.
fifo_ferr  output  1  framing flag of the head entry.
fifo_oerr  output  1  overrun flag of the head entry.
fifo_empty  output  1  FIFO holds 0 entries.
fifo_full  output  1  FIFO holds 2**ADDR_BITS entries.
fifo_count  output  ADDR_BITS+1  current entry count (0..8).
underflow  output  1  sticky: a pop was attempted while empty.
clear_err  input  1  clears underflow.

Behaviour:
- Reset (n_rst low at a clock edge):
  - Pointers and count go to 0; FSM goes to IDLE.
  - data_read=0, underflow=0, fifo_empty=1, fifo_full=0, fifo_count=0.
  - fifo_data, fifo_ferr and fifo_oerr read 0 while the FIFO is empty.
  - Storage contents are don't-care.
  - A reset in the middle of an ACK discards the pending acknowledge. The byte stays in the receiver and is re-captured after reset.
- Capture FSM, 3 states:
  - IDLE: if data_ready=1 and fifo_full=0 at the edge, write {framing_error, overrun_error, rx_data} to mem[wptr], advance wptr (mod depth), go to ACK. Otherwise stay in IDLE.
  - ACK: data_read=1 for exactly this cycle (decoded from state). Always go to GAP.
  - GAP: data_read=0. data_ready is ignored for this cycle because the receiver is clearing it. Always go to IDLE.
  - Minimum spacing between captures is 3 cycles.
- Full condition: while fifo_full=1, no capture and no data_read. The byte waits in the receiver; any overrun is reported by the receiver on the following byte, not by this block.
  - The full check uses the count before any same-cycle pop. A push and pop in the same cycle while full: the pop happens, the push waits until the next IDLE evaluation.
- Pop side:
  - fifo_data, fifo_ferr and fifo_oerr always reflect mem[rptr] (combinational from registered state).
  - fifo_pop=1 with fifo_empty=0 advances rptr (mod depth) at the edge.
  - fifo_pop=1 with fifo_empty=1 is ignored and sets underflow. This applies even if a push occurs in the same cycle.
- Count:
  - push only: +1; pop only: -1; both: unchanged.
  - fifo_empty = (count==0); fifo_full = (count==2**ADDR_BITS). Both are registered and consistent with count.
- Latency: a byte captured at edge N is visible on fifo_data and counted in fifo_count after edge N.
- underflow is cleared by clear_err=1. If clear_err and an empty pop occur in the same cycle, set wins.
- Pointer wrap: both pointers wrap from 7 to 0. Ordering is strictly FIFO across the wrap.

Test Plan:
- Reset, then data_ready=1 with rx_data=0xA5 and errors 0 → data_read pulses once, 1 cycle after the capture edge. fifo_count=1, fifo_data=0xA5, fifo_empty=0.
- Push 8 bytes 0x01..0x08 with no pops → fifo_full=1, fifo_count=8. A 9th byte 0x09 held on data_ready gets no data_read. One pop → 0x09 is captured within 3 cycles, count returns to 8.
- Ten bytes pushed and popped interleaved so the pointers wrap → pop order is exactly the push order, and count never exceeds 8.
- Byte 0x3C with framing_error=1, then 0x3D with overrun_error=1 → head entries show fifo_ferr=1/fifo_oerr=0, then fifo_ferr=0/fifo_oerr=1.
- Pop while empty → underflow=1 and stays set; clear_err pulse → underflow=0. Empty pop and clear_err in the same cycle → underflow=1.
- Assert n_rst=0 during ACK with count=3 → next cycle data_read=0, count=0, fifo_empty=1. After release, the still-pending byte is captured again.
